// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cursor_pkg
// Description : Shared grid geometry, state/move encodings and coordinate
//               stepping helper for the cursor painter.
// Revision    : 1.0 - initial release
// ============================================================================
package cursor_pkg;

  localparam int GRID_DIM = 8;
  localparam int COORD_W  = 3;
  localparam int ADDR_W   = 6;
  localparam int PIX_W    = 24;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2,
    DRAW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MV_UP    = 2'd0,
    MV_DOWN  = 2'd1,
    MV_LEFT  = 2'd2,
    MV_RIGHT = 2'd3
  } move_e;

  typedef logic [COORD_W-1:0] coord_t;

  // One step along an axis; wraps modulo the grid or clamps at the edges.
  function automatic coord_t step_coord(input coord_t c, input logic dec, input logic wrap);
    coord_t edge_c;
    edge_c = dec ? '0 : coord_t'(GRID_DIM - 1);
    if (!wrap && (c == edge_c)) begin
      step_coord = c;
    end else if (dec) begin
      step_coord = c - coord_t'(1);
    end else begin
      step_coord = c + coord_t'(1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_painter_if.sv
`default_nettype none
// ============================================================================
// Module      : cursor_painter_if
// Description : Frame-buffer write channel (valid/ready, address, pixel).
// Revision    : 1.0 - initial release
// ============================================================================
interface cursor_painter_if;
  import cursor_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface
`default_nettype wire

// File: rtl/cursor_painter_move_latch.sv
`default_nettype none
// ============================================================================
// Module      : move_latch
// Description : One-deep pending-move register. Simultaneous pulses resolve
//               up > down > left > right; a new pulse always overwrites.
// Revision    : 1.0 - initial release
// ============================================================================
module move_latch
  import cursor_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  logic  consume,
  input  logic  up,
  input  logic  down,
  input  logic  left,
  input  logic  right,
  output logic  pending_valid,
  output move_e pending_move
);

  logic  w_any;
  move_e w_move;
  logic  r_valid;
  move_e r_move;

  // Priority-encode the incoming pulses into a single move.
  always_comb begin
    w_any  = up | down | left | right;
    w_move = MV_RIGHT;
    if (up) begin
      w_move = MV_UP;
    end else if (down) begin
      w_move = MV_DOWN;
    end else if (left) begin
      w_move = MV_LEFT;
    end
  end

  // A fresh pulse wins over consumption so a move arriving on the evaluate cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_move  <= MV_UP;
    end else if (!enable) begin
      r_valid <= 1'b0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_move  <= w_move;
    end else if (consume) begin
      r_valid <= 1'b0;
    end
  end

  assign pending_valid = r_valid;
  assign pending_move  = r_move;

endmodule
`default_nettype wire

// File: rtl/cursor_painter.sv
`default_nettype none
// ============================================================================
// Module      : cursor_painter
// Description : Moves a single-pixel cursor on an 8x8 frame buffer, erasing
//               the old pixel and painting the new one over a valid/ready
//               write channel.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_painter
  import cursor_pkg::*;
#(
  parameter logic [PIX_W-1:0] COLOR = 24'hFFFFFF,
  parameter int               WRAP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                shield_ready,
  cursor_painter_if.master    wr,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic                busy
);

  localparam logic c_wrap = (WRAP != 0);

  state_e            r_state;
  coord_t            r_x, r_y, r_tx, r_ty;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_busy;

  logic   w_pending;
  move_e  w_move;
  coord_t w_tx, w_ty;
  logic   w_differs;

  move_latch u_move_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (r_state != INIT),
    .consume       (r_state == IDLE),
    .up            (up),
    .down          (down),
    .left          (left),
    .right         (right),
    .pending_valid (w_pending),
    .pending_move  (w_move)
  );

  // Target position for the pending move; equal to (x,y) when clamped.
  always_comb begin
    w_tx = r_x;
    w_ty = r_y;
    unique case (w_move)
      MV_UP:    w_ty = step_coord(r_y, 1'b1, c_wrap);
      MV_DOWN:  w_ty = step_coord(r_y, 1'b0, c_wrap);
      MV_LEFT:  w_tx = step_coord(r_x, 1'b1, c_wrap);
      MV_RIGHT: w_tx = step_coord(r_x, 1'b0, c_wrap);
      default:  ;
    endcase
    w_differs = (w_tx != r_x) || (w_ty != r_y);
  end

  // Control FSM; all write-channel outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_x        <= '0;
      r_y        <= '0;
      r_tx       <= '0;
      r_ty       <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b1;
    end else begin
      unique case (r_state)
        INIT: begin
          if (shield_ready) begin
            r_state    <= DRAW;
            r_tx       <= '0;
            r_ty       <= '0;
            r_wr_valid <= 1'b1;
            r_wr_addr  <= {r_y, r_x};
            r_wr_data  <= COLOR;
          end
        end
        IDLE: begin
          if (w_pending && w_differs) begin
            r_state    <= CLEAR;
            r_tx       <= w_tx;
            r_ty       <= w_ty;
            r_wr_valid <= 1'b1;
            r_wr_addr  <= {r_y, r_x};
            r_wr_data  <= '0;
            r_busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (wr.wr_ready) begin
            r_state   <= DRAW;
            r_x       <= r_tx;
            r_y       <= r_ty;
            r_wr_addr <= {r_ty, r_tx};
            r_wr_data <= COLOR;
          end
        end
        DRAW: begin
          if (wr.wr_ready) begin
            r_state    <= IDLE;
            r_wr_valid <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign wr.wr_valid = r_wr_valid;
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_data  = r_wr_data;
  assign x           = r_x;
  assign y           = r_y;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/cursor_painter.md
CURSOR_PAINTER -- requirements
Module: cursor_painter

Interface
REQ-001 SHALL have parameter COLOR, default 24'hFFFFFF: cursor pixel value {R,G,B}, 8 bits each.
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap at grid edges, 0 = saturate.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports up, down, left, right  input  1 each  single-cycle move pulses.
REQ-006 SHALL have port shield_ready  input  1  high once the display shield accepts frame writes.
REQ-007 SHALL have port wr_valid  output  1  frame-buffer write request.
REQ-008 SHALL have port wr_ready  input  1  frame-buffer write accept.
REQ-009 SHALL have port wr_addr  output  6  pixel address {row[2:0], col[2:0]}.
REQ-010 SHALL have port wr_data  output  24  pixel value {R,G,B}.
REQ-011 SHALL have ports x, y  output  3 each  current cursor column and row.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states INIT, IDLE, CLEAR, DRAW.
REQ-014 INIT SHALL hold until shield_ready=1, then go to DRAW with target (0,0).
REQ-015 A write SHALL complete on a cycle with wr_valid=1 and wr_ready=1; while wr_valid=1 and wr_ready=0, wr_addr and wr_data SHALL stay stable.
REQ-016 wr_valid SHALL be high exactly in CLEAR and DRAW.
REQ-017 In IDLE with a move pending, SHALL compute the target position; if it differs from (x,y), go to CLEAR next cycle; otherwise drop the move and stay in IDLE.
REQ-018 CLEAR SHALL drive wr_addr={y,x} and wr_data=0.
REQ-019 When CLEAR completes, x,y SHALL take the target position and state SHALL go to DRAW.
REQ-020 DRAW SHALL drive wr_addr={y,x} and wr_data=COLOR; on completion, state SHALL go to IDLE.
REQ-021 Direction mapping: up = y-1, down = y+1, left = x-1, right = x+1.
REQ-022 WRAP=1: arithmetic SHALL be 3-bit modulo 8 (7+1 = 0, 0-1 = 7).
REQ-023 WRAP=0: SHALL clamp to 0..7; a clamped move SHALL produce no writes.
REQ-024 The pending-move register SHALL be one deep; a move pulse in any state SHALL overwrite it.
REQ-025 If several pulses arrive in one cycle, exactly one move SHALL be recorded, priority up > down > left > right.
REQ-026 The pending move SHALL be consumed on the IDLE cycle that evaluates it.
REQ-027 A pulse arriving in that same cycle SHALL become the new pending move.
REQ-028 Pulses received in INIT SHALL be discarded.
REQ-029 Move-to-first-write latency SHALL be 2 cycles: pulse at cycle N, IDLE evaluation at N+1, wr_valid at N+2.
REQ-030 shield_ready falling outside INIT SHALL have no effect.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state=INIT, x=0, y=0, pending empty, wr_valid=0, wr_addr=0, wr_data=0 and busy=1.
REQ-032 Reset during CLEAR or DRAW SHALL abandon the write; after release the block SHALL redraw (0,0) only, with no clear of the old pixel.

Structure
REQ-033 Package cursor_pkg SHALL hold GRID_DIM=8, COORD_W=3, ADDR_W=6, PIX_W=24 and the state enumeration.
REQ-034 Sub-module move_latch SHALL implement the priority-encoded, overwrite-on-new, one-deep pending-move register.
REQ-035 All other logic SHALL sit in cursor_painter.

Verification
REQ-036 Release reset with shield_ready=0 for 10 cycles, then 1, wr_ready=1 -> no writes while low; then one write addr 0 data FFFFFF; busy falls.
REQ-037 At (0,0), pulse right, wr_ready=1 -> write (addr 0, data 0) at N+2, then (addr 1, data FFFFFF); x=1.
REQ-038 At (0,0), WRAP=1, pulse up -> writes addr 0 then addr 56 (row 7); y=7. WRAP=0, same stimulus -> no writes, busy stays 0.
REQ-039 Hold wr_ready=0 for 5 cycles during CLEAR -> wr_valid, wr_addr, wr_data stable; single completion when wr_ready rises.
REQ-040 During DRAW, pulse left then down -> only down executed after IDLE. Pulse up+right in the same cycle -> only up executed.
REQ-041 Assert rst_n mid-CLEAR at (3,4) -> outputs reset the same cycle; after release, only addr 0 is drawn.
